// File: rtl/div_iter_if.sv
// Handshake and data bundle between the execute stage and the iterative divider.
// DIV_REMAINDER_EN adds the signed remainder output to the bundle.
interface div_iter_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             data_busy;
`ifdef DIV_REMAINDER_EN
  logic [WIDTH-1:0] data_remainder;
`endif

  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY, data_busy
`ifdef DIV_REMAINDER_EN
    , input data_remainder
`endif
  );

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY, data_busy
`ifdef DIV_REMAINDER_EN
    , output data_remainder
`endif
  );
endinterface

// File: rtl/div_iter.sv
// Multicycle signed restoring divider, one quotient bit per clock.
// Optional signed remainder output enabled by DIV_REMAINDER_EN.
module div_iter #(
  parameter int WIDTH = 32
) (
  input logic     clock,
  input logic     reset_n,
  div_iter_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ITER, FIX, DZ} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic             sign_a, sign_b, ovf;
  logic [WIDTH-1:0] divisor, rem, quo;
  logic [WIDTH:0]   rem_sh, trial;
  logic             last_bit;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
    return (x < 0) ? negate(x) : x;
  endfunction

  // Trial subtraction at WIDTH+1 bits so the sign bit is never lost.
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign trial    = rem_sh + ~{1'b0, divisor} + (WIDTH+1)'(1);
  assign last_bit = (count == CNT_W'(WIDTH-1));

  assign bus.data_busy = (state != IDLE);

  always_comb begin
    state_next = state;
    if (bus.ctrl_DIV) begin
      state_next = (bus.data_operandB == '0) ? DZ : ITER;
    end else begin
      case (state)
        ITER:    if (last_bit) state_next = FIX;
        FIX:     state_next = IDLE;
        DZ:      state_next = IDLE;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // A start on any edge overrides completion, so a restart never emits RDY.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count              <= '0;
      bus.data_resultRDY <= 1'b0;
      bus.data_result    <= '0;
      bus.data_exception <= 1'b0;
`ifdef DIV_REMAINDER_EN
      bus.data_remainder <= '0;
`endif
    end else begin
      bus.data_resultRDY <= 1'b0;
      if (bus.ctrl_DIV) begin
        count <= '0;
      end else begin
        case (state)
          ITER: count <= last_bit ? '0 : count + CNT_W'(1);
          FIX: begin
            bus.data_resultRDY <= 1'b1;
            bus.data_exception <= ovf;
            bus.data_result    <= ovf ? MIN_INT : ((sign_a ^ sign_b) ? negate(quo) : quo);
`ifdef DIV_REMAINDER_EN
            bus.data_remainder <= ovf ? '0 : (sign_a ? negate(rem) : rem);
`endif
          end
          DZ: begin
            bus.data_resultRDY <= 1'b1;
            bus.data_exception <= 1'b1;
            bus.data_result    <= '0;
`ifdef DIV_REMAINDER_EN
            bus.data_remainder <= '0;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  // Datapath: quo starts as |A| and is shifted out into rem as quotient bits shift in.
  always_ff @(posedge clock) begin
    if (bus.ctrl_DIV) begin
      sign_a  <= bus.data_operandA[WIDTH-1];
      sign_b  <= bus.data_operandB[WIDTH-1];
      ovf     <= (bus.data_operandA == MIN_INT) && (bus.data_operandB == '1);
      divisor <= magnitude(bus.data_operandB);
      quo     <= magnitude(bus.data_operandA);
      rem     <= '0;
    end else if (state == ITER) begin
      if (!trial[WIDTH]) begin
        rem <= trial[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= rem_sh[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end
endmodule

// File: tb/tb_div_iter.sv
// Directed self-checking bench for div_iter (WIDTH=32).
// Remainder checks are compiled in when DIV_REMAINDER_EN is defined.
module tb_div_iter;
  localparam int W = 32;

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  div_iter_if #(.WIDTH(W)) bus();

  div_iter #(.WIDTH(W)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    bus.ctrl_DIV      = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(negedge clock);
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
  endtask

  // Returns the number of edges after the start edge at which RDY was seen, 0 on timeout.
  task automatic wait_rdy(output int edges);
    edges = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      if (bus.data_resultRDY) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.data_result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", bus.data_result); end
    checks++; if (bus.data_exception !== 1'b0) begin errors++; $display("FAIL reset_exc got %b want 0", bus.data_exception); end
    checks++; if (bus.data_resultRDY !== 1'b0) begin errors++; $display("FAIL reset_rdy got %b want 0", bus.data_resultRDY); end
    checks++; if (bus.data_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.data_busy); end
`ifdef DIV_REMAINDER_EN
    checks++; if (bus.data_remainder !== '0) begin errors++; $display("FAIL reset_rem got %h want 0", bus.data_remainder); end
`endif
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] va [5] = '{32'd100, 32'hFFFF_FF9C, 32'd100, 32'd0, 32'hFFFF_FFF9};
    logic [W-1:0] vb [5] = '{32'd7, 32'd7, 32'hFFFF_FFF9, 32'd5, 32'd2};
    logic [W-1:0] vq [5] = '{32'd14, 32'hFFFF_FFF2, 32'hFFFF_FFF2, 32'd0, 32'hFFFF_FFFD};
    logic [W-1:0] vr [5] = '{32'd2, 32'hFFFF_FFFE, 32'd2, 32'd0, 32'hFFFF_FFFF};
    int e;
    for (int i = 0; i < 5; i++) begin
      start_op(va[i], vb[i]);
      checks++; if (bus.data_busy !== 1'b1) begin errors++; $display("FAIL basic_busy[%0d] got %b want 1", i, bus.data_busy); end
      wait_rdy(e);
      checks++; if (e !== 33) begin errors++; $display("FAIL basic_latency[%0d] got %0d want 33", i, e); end
      checks++; if (bus.data_result !== vq[i]) begin errors++; $display("FAIL basic_result[%0d] got %h want %h", i, bus.data_result, vq[i]); end
      checks++; if (bus.data_exception !== 1'b0) begin errors++; $display("FAIL basic_exc[%0d] got %b want 0", i, bus.data_exception); end
`ifdef DIV_REMAINDER_EN
      checks++; if (bus.data_remainder !== vr[i]) begin errors++; $display("FAIL basic_rem[%0d] got %h want %h", i, bus.data_remainder, vr[i]); end
`else
      if (vr[i] === 'x) $display("unreachable");
`endif
      @(negedge clock);
      checks++; if (bus.data_resultRDY !== 1'b0) begin errors++; $display("FAIL basic_pulse[%0d] got %b want 0", i, bus.data_resultRDY); end
      checks++; if (bus.data_result !== vq[i]) begin errors++; $display("FAIL basic_hold[%0d] got %h want %h", i, bus.data_result, vq[i]); end
    end
  endtask

  task automatic test_div_zero();
    int e;
    start_op(32'd5, 32'd0);
    checks++; if (bus.data_busy !== 1'b1) begin errors++; $display("FAIL dz_busy got %b want 1", bus.data_busy); end
    wait_rdy(e);
    checks++; if (e !== 1) begin errors++; $display("FAIL dz_latency got %0d want 1", e); end
    checks++; if (bus.data_result !== '0) begin errors++; $display("FAIL dz_result got %h want 0", bus.data_result); end
    checks++; if (bus.data_exception !== 1'b1) begin errors++; $display("FAIL dz_exc got %b want 1", bus.data_exception); end
    checks++; if (bus.data_busy !== 1'b0) begin errors++; $display("FAIL dz_busy_after got %b want 0", bus.data_busy); end
`ifdef DIV_REMAINDER_EN
    checks++; if (bus.data_remainder !== '0) begin errors++; $display("FAIL dz_rem got %h want 0", bus.data_remainder); end
`endif
    @(negedge clock);
    checks++; if (bus.data_resultRDY !== 1'b0) begin errors++; $display("FAIL dz_pulse got %b want 0", bus.data_resultRDY); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] vb [2] = '{32'd1, 32'hFFFF_FFFF};
    logic         vx [2] = '{1'b0, 1'b1};
    int e;
    for (int i = 0; i < 2; i++) begin
      start_op(32'h8000_0000, vb[i]);
      wait_rdy(e);
      checks++; if (e !== 33) begin errors++; $display("FAIL ovf_latency[%0d] got %0d want 33", i, e); end
      checks++; if (bus.data_result !== 32'h8000_0000) begin errors++; $display("FAIL ovf_result[%0d] got %h want 80000000", i, bus.data_result); end
      checks++; if (bus.data_exception !== vx[i]) begin errors++; $display("FAIL ovf_exc[%0d] got %b want %b", i, bus.data_exception, vx[i]); end
`ifdef DIV_REMAINDER_EN
      checks++; if (bus.data_remainder !== '0) begin errors++; $display("FAIL ovf_rem[%0d] got %h want 0", i, bus.data_remainder); end
`endif
    end
  endtask

  task automatic test_restart();
    int e;
    int seen = 0;
    start_op(32'd100, 32'd7);
    repeat (9) begin @(negedge clock); if (bus.data_resultRDY) seen++; end
    bus.ctrl_DIV = 1'b1; bus.data_operandA = 32'd81; bus.data_operandB = 32'd9;
    @(negedge clock);
    bus.ctrl_DIV = 1'b0; bus.data_operandA = '0; bus.data_operandB = '0;
    wait_rdy(e);
    checks++; if (e !== 33) begin errors++; $display("FAIL restart_latency got %0d want 33", e); end
    checks++; if (bus.data_result !== 32'd9) begin errors++; $display("FAIL restart_result got %h want 9", bus.data_result); end
    repeat (40) begin @(negedge clock); if (bus.data_resultRDY) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL restart_extra_rdy got %0d want 0", seen); end
  endtask

  task automatic test_restart_on_rdy();
    int e;
    int seen = 0;
    start_op(32'd10, 32'd2);
    repeat (32) begin @(negedge clock); if (bus.data_resultRDY) seen++; end
    bus.ctrl_DIV = 1'b1; bus.data_operandA = 32'd20; bus.data_operandB = 32'd4;
    @(negedge clock);
    bus.ctrl_DIV = 1'b0;
    if (bus.data_resultRDY) seen++;
    checks++; if (seen !== 0) begin errors++; $display("FAIL collide_rdy got %0d want 0", seen); end
    wait_rdy(e);
    checks++; if (e !== 33) begin errors++; $display("FAIL collide_latency got %0d want 33", e); end
    checks++; if (bus.data_result !== 32'd5) begin errors++; $display("FAIL collide_result got %h want 5", bus.data_result); end
  endtask

  task automatic test_async_reset();
    int seen = 0;
    start_op(32'h8000_0000, 32'hFFFF_FFFF);
    begin int e; wait_rdy(e); end
    start_op(32'd100, 32'd7);
    repeat (19) @(negedge clock);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++; if (bus.data_result !== '0) begin errors++; $display("FAIL areset_result got %h want 0", bus.data_result); end
    checks++; if (bus.data_exception !== 1'b0) begin errors++; $display("FAIL areset_exc got %b want 0", bus.data_exception); end
    checks++; if (bus.data_busy !== 1'b0) begin errors++; $display("FAIL areset_busy got %b want 0", bus.data_busy); end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (60) begin @(negedge clock); if (bus.data_resultRDY) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL areset_stale_rdy got %0d want 0", seen); end
    checks++; if (bus.data_busy !== 1'b0) begin errors++; $display("FAIL areset_idle got %b want 0", bus.data_busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_overflow();
    test_restart();
    test_restart_on_rdy();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
